// File: rtl/imm_extend_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe_pkg
// Purpose  : Shared decode constants for the pipelined immediate generator.
// Revision : 1.0 - initial release
// ============================================================================
package imm_extend_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_ALU = 2'd0,
        MODE_MEM = 2'd1,
        MODE_BR  = 2'd2,
        MODE_BAD = 2'd3
    } imm_mode_e;

    localparam logic [1:0] IMM_MODE_ALU = 2'd0;
    localparam logic [1:0] IMM_MODE_MEM = 2'd1;
    localparam logic [1:0] IMM_MODE_BR  = 2'd2;
    localparam logic [1:0] IMM_MODE_BAD = 2'd3;

    localparam int IMM_DEF_IN_W     = 24;
    localparam int IMM_DEF_OUT_W    = 32;
    localparam int IMM_DEF_ALU_W    = 8;
    localparam int IMM_DEF_MEM_W    = 12;
    localparam int IMM_DEF_BR_W     = 24;
    localparam int IMM_DEF_BR_SHIFT = 2;
    localparam int IMM_DEF_ERR_W    = 8;

endpackage
`default_nettype wire

// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe_if
// Purpose  : Decode-side input and execute-side output handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface imm_extend_pipe_if #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 32,
    parameter int ERR_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             in_sign;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic             out_err;
    logic [ERR_W-1:0] err_cnt;
    logic             err_clr;

    modport master (
        output in_valid, in_imm, in_mode, in_sign, out_ready, err_clr,
        input  in_ready, out_valid, out_imm, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_sign, out_ready, err_clr,
        output in_ready, out_valid, out_imm, out_err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/imm_extend_pipe_core.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_core
// Purpose  : Combinational field select, sign/zero extension and branch scaling.
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W     = IMM_DEF_IN_W,
    parameter int OUT_W    = IMM_DEF_OUT_W,
    parameter int ALU_W    = IMM_DEF_ALU_W,
    parameter int MEM_W    = IMM_DEF_MEM_W,
    parameter int BR_W     = IMM_DEF_BR_W,
    parameter int BR_SHIFT = IMM_DEF_BR_SHIFT
) (
    input  wire logic [IN_W-1:0]  in_imm,
    input  wire logic [1:0]       in_mode,
    input  wire logic             in_sign,
    output logic      [OUT_W-1:0] ext,
    output logic                  err
);

    logic [ALU_W-1:0] w_alu_f;
    logic [MEM_W-1:0] w_mem_f;
    logic [BR_W-1:0]  w_br_f;
    logic [OUT_W-1:0] w_alu_ext;
    logic [OUT_W-1:0] w_mem_ext;
    logic [OUT_W-1:0] w_br_ext;

    assign w_alu_f = in_imm[ALU_W-1:0];
    assign w_mem_f = in_imm[MEM_W-1:0];
    assign w_br_f  = in_imm[BR_W-1:0];

    // A size cast of a signed operand replicates its top bit.
    assign w_alu_ext = in_sign ? OUT_W'($signed(w_alu_f)) : OUT_W'(w_alu_f);
    assign w_mem_ext = in_sign ? OUT_W'($signed(w_mem_f)) : OUT_W'(w_mem_f);
    assign w_br_ext  = in_sign ? OUT_W'($signed(w_br_f))  : OUT_W'(w_br_f);

    always_comb begin
        ext = '0;
        err = 1'b0;
        case (in_mode)
            IMM_MODE_ALU: ext = w_alu_ext;
            IMM_MODE_MEM: ext = w_mem_ext;
            IMM_MODE_BR:  ext = w_br_ext << BR_SHIFT;
            default:      err = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Purpose  : Registered immediate generator with skid buffer and error counter.
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W     = IMM_DEF_IN_W,
    parameter int OUT_W    = IMM_DEF_OUT_W,
    parameter int ALU_W    = IMM_DEF_ALU_W,
    parameter int MEM_W    = IMM_DEF_MEM_W,
    parameter int BR_W     = IMM_DEF_BR_W,
    parameter int BR_SHIFT = IMM_DEF_BR_SHIFT,
    parameter int ERR_W    = IMM_DEF_ERR_W
) (
    input wire logic         clk,
    input wire logic         rst_n,
    imm_extend_pipe_if.slave bus
);

    generate
        if (IN_W < 1 || OUT_W < 1 || ALU_W < 1 || MEM_W < 1 || BR_W < 1 ||
            ERR_W < 1 || BR_SHIFT < 0 ||
            ALU_W > IN_W || MEM_W > IN_W || BR_W > IN_W ||
            BR_W + BR_SHIFT > OUT_W) begin : g_bad_params
            $fatal(1, "imm_extend_pipe: illegal width parameters");
        end
    endgenerate

    logic [OUT_W-1:0] w_ext;
    logic             w_ext_err;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_load;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_imm;
    logic             r_out_err;
    logic             r_skid_valid;
    logic [OUT_W-1:0] r_skid_imm;
    logic             r_skid_err;
    logic [ERR_W-1:0] r_err_cnt;

    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .ALU_W    (ALU_W),
        .MEM_W    (MEM_W),
        .BR_W     (BR_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .in_imm  (bus.in_imm),
        .in_mode (bus.in_mode),
        .in_sign (bus.in_sign),
        .ext     (w_ext),
        .err     (w_ext_err)
    );

    assign w_in_ready = rst_n && !r_skid_valid;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_load = !r_out_valid || bus.out_ready;

    // The skid entry is always older than any new input, so it drains first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_err   <= 1'b0;
        end else if (w_out_load) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_imm    <= r_skid_imm;
                r_out_err    <= r_skid_err;
                r_skid_valid <= w_accept;
                if (w_accept) begin
                    r_skid_imm <= w_ext;
                    r_skid_err <= w_ext_err;
                end
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_imm   <= w_ext;
                r_out_err   <= w_ext_err;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_ext;
            r_skid_err   <= w_ext_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (bus.err_clr) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_ext_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_imm   = r_out_imm;
    assign bus.out_err   = r_out_err;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Purpose  : Directed and streaming checks for imm_extend_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    imm_extend_pipe_if #(.IN_W(24), .OUT_W(32), .ERR_W(8)) bus ();

    imm_extend_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for the default widths, returns {err, value}.
    function automatic logic [32:0] model_ext(input logic [1:0] mode, input logic sign,
                                              input logic [23:0] imm);
        logic [31:0] v;
        v = 32'h0;
        case (mode)
            2'd0: v = {{24{sign & imm[7]}}, imm[7:0]};
            2'd1: v = {{20{sign & imm[11]}}, imm[11:0]};
            2'd2: v = {{6{sign & imm[23]}}, imm[23:0], 2'b00};
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_one(input logic [1:0] mode, input logic sign, input logic [23:0] imm);
        bus.in_mode  = mode;
        bus.in_sign  = sign;
        bus.in_imm   = imm;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_imm !== 32'h0) $display("FAIL reset_out_imm got %h want 0", bus.out_imm); else pass_cnt++;
        total_cnt++; if (bus.out_err !== 1'b0) $display("FAIL reset_out_err got %b want 0", bus.out_err); else pass_cnt++;
        total_cnt++; if (bus.err_cnt !== 8'h0) $display("FAIL reset_err_cnt got %h want 0", bus.err_cnt); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", bus.in_ready); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
    endtask

    task automatic test_alu();
        drive_one(2'd0, 1'b1, 24'h0000FF);
        total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL alu_valid got %b want 1", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_imm !== 32'hFFFFFFFF) $display("FAIL alu_sext got %h want ffffffff", bus.out_imm); else pass_cnt++;
        total_cnt++; if (bus.out_err !== 1'b0) $display("FAIL alu_err got %b want 0", bus.out_err); else pass_cnt++;
        drive_one(2'd0, 1'b0, 24'h0000FF);
        total_cnt++; if (bus.out_imm !== 32'h000000FF) $display("FAIL alu_zext got %h want 000000ff", bus.out_imm); else pass_cnt++;
        step();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL alu_idle_valid got %b want 0", bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_mem();
        drive_one(2'd1, 1'b1, 24'h000800);
        total_cnt++; if (bus.out_imm !== 32'hFFFFF800) $display("FAIL mem_sext got %h want fffff800", bus.out_imm); else pass_cnt++;
        drive_one(2'd1, 1'b1, 24'hABC7FF);
        total_cnt++; if (bus.out_imm !== 32'h000007FF) $display("FAIL mem_upper_ignored got %h want 000007ff", bus.out_imm); else pass_cnt++;
        step();
    endtask

    task automatic test_branch();
        drive_one(2'd2, 1'b1, 24'h800000);
        total_cnt++; if (bus.out_imm !== 32'hFE000000) $display("FAIL br_sext got %h want fe000000", bus.out_imm); else pass_cnt++;
        drive_one(2'd2, 1'b0, 24'h000001);
        total_cnt++; if (bus.out_imm !== 32'h00000004) $display("FAIL br_shift got %h want 00000004", bus.out_imm); else pass_cnt++;
        step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive_one(2'd0, 1'b0, 24'h000012);
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_after_a got %b want 1", bus.in_ready); else pass_cnt++;
        drive_one(2'd1, 1'b0, 24'h000345);
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_after_b got %b want 0", bus.in_ready); else pass_cnt++;
        total_cnt++; if (bus.out_imm !== 32'h12) $display("FAIL bp_hold_a got %h want 00000012", bus.out_imm); else pass_cnt++;
        step();
        total_cnt++; if (bus.out_imm !== 32'h12 || bus.out_valid !== 1'b1) $display("FAIL bp_stable_a got %h/%b want 00000012/1", bus.out_imm, bus.out_valid); else pass_cnt++;
        bus.out_ready = 1'b1;
        step();
        total_cnt++; if (bus.out_imm !== 32'h345 || bus.out_valid !== 1'b1) $display("FAIL bp_then_b got %h/%b want 00000345/1", bus.out_imm, bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_restored got %b want 1", bus.in_ready); else pass_cnt++;
        step();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_no_dup got %b want 0", bus.out_valid); else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [32:0] q[$];
        logic [32:0] exp;
        int          n_items;
        int          k;
        int          popped;
        int          cyc;
        n_items = 1000;
        k = 0;
        popped = 0;
        cyc = 0;
        bus.in_mode = 2'($urandom_range(0, 2));
        bus.in_sign = 1'($urandom);
        bus.in_imm  = 24'($urandom);
        while (popped < n_items && cyc < 10000) begin
            bus.in_valid  = (k < n_items);
            bus.out_ready = 1'($urandom);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model_ext(bus.in_mode, bus.in_sign, bus.in_imm));
                k++;
            end
            if (bus.out_valid && bus.out_ready) begin
                total_cnt++;
                if (q.size() == 0) begin
                    $display("FAIL stream_spurious got %h want nothing", bus.out_imm);
                end else begin
                    exp = q.pop_front();
                    if ({bus.out_err, bus.out_imm} !== exp)
                        $display("FAIL stream_item%0d got %b/%h want %b/%h", popped,
                                 bus.out_err, bus.out_imm, exp[32], exp[31:0]);
                    else
                        pass_cnt++;
                end
                popped++;
            end
            @(posedge clk);
            #1;
            if (k > 0 && bus.in_valid && !bus.in_ready) begin
                // input still pending: hold it
            end
            cyc++;
            if (bus.in_valid && q.size() > 0 && k < n_items) begin
                bus.in_mode = 2'($urandom_range(0, 2));
                bus.in_sign = 1'($urandom);
                bus.in_imm  = 24'($urandom);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        total_cnt++;
        if (popped != n_items || q.size() != 0)
            $display("FAIL stream_count got %0d left %0d want %0d left 0", popped, q.size(), n_items);
        else
            pass_cnt++;
        step();
        step();
    endtask

    task automatic test_illegal();
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_one(2'd3, 1'b1, 24'hFFFFFF);
            total_cnt++; if (bus.out_imm !== 32'h0 || bus.out_err !== 1'b1) $display("FAIL bad_out%0d got %h/%b want 00000000/1", i, bus.out_imm, bus.out_err); else pass_cnt++;
        end
        total_cnt++; if (bus.err_cnt !== 8'd3) $display("FAIL bad_cnt3 got %0d want 3", bus.err_cnt); else pass_cnt++;
        bus.err_clr = 1'b1;
        drive_one(2'd3, 1'b0, 24'h000001);
        bus.err_clr = 1'b0;
        total_cnt++; if (bus.err_cnt !== 8'd0) $display("FAIL bad_clr_prio got %0d want 0", bus.err_cnt); else pass_cnt++;
        total_cnt++; if (bus.out_err !== 1'b1) $display("FAIL bad_clr_out_err got %b want 1", bus.out_err); else pass_cnt++;
        bus.in_mode  = 2'd3;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 254; i++) step();
        total_cnt++; if (bus.err_cnt !== 8'hFE) $display("FAIL bad_cnt254 got %h want fe", bus.err_cnt); else pass_cnt++;
        step();
        total_cnt++; if (bus.err_cnt !== 8'hFF) $display("FAIL bad_cnt255 got %h want ff", bus.err_cnt); else pass_cnt++;
        step();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.err_cnt !== 8'hFF) $display("FAIL bad_saturate got %h want ff", bus.err_cnt); else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive_one(2'd0, 1'b0, 24'h000055);
        drive_one(2'd0, 1'b0, 24'h000066);
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL rmid_full got %b want 0", bus.in_ready); else pass_cnt++;
        rst_n = 1'b0;
        step();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_out_valid got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL rmid_in_ready_low got %b want 0", bus.in_ready); else pass_cnt++;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rmid_in_ready_rel got %b want 1", bus.in_ready); else pass_cnt++;
        drive_one(2'd0, 1'b0, 24'h000077);
        total_cnt++; if (bus.out_imm !== 32'h77 || bus.out_valid !== 1'b1) $display("FAIL rmid_new got %h/%b want 00000077/1", bus.out_imm, bus.out_valid); else pass_cnt++;
        step();
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_alone got %b want 0", bus.out_valid); else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_mode   = 2'd0;
        bus.in_sign   = 1'b0;
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_backpressure();
        test_stream();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
